led_fade_pwm: RTL
=================

# led_fade_pwm

Downstream stage of the 8-bit LED shift pattern generator, sitting between its `led[7:0]` output and the board LED pins. Each channel switches on at full brightness while its pattern bit is 1. When the bit drops to 0, the channel fades out linearly under PWM control, which gives the running pattern a visible decaying tail. Fully synchronous to the pattern generator's clock: one clock, no CDC.

## Interface
- `PWM_BITS`, default 8: PWM counter width; PWM period = 2^PWM_BITS clocks; MAX = 2^PWM_BITS-1.
- `FADE_DIV`, default 65536: clocks per fade tick (≥2).
- `FADE_STEP`, default 16: level decrement per fade tick (1..MAX).
- `clk` in 1: system clock, rising edge.
- `rs` in 1: reset, asynchronous, active-high.
- `pat` in 8: pattern from the shift stage, same clock domain, sampled every rising edge.
- `led_out` out 8: registered PWM drive, 1 = LED on.
- `frame` out 1: registered one-cycle pulse, high during the cycle in which the PWM counter is 0.

## Operation
- **PWM counter `cnt`** (PWM_BITS wide):
  - Increments every clock and wraps MAX→0.
  - The edge where `cnt`==MAX is the period boundary.
- **Fade prescaler `pre`:**
  - Counts 0..FADE_DIV-1 and wraps.
  - `fade_tick` is combinational and true while `pre`==FADE_DIV-1.
- **Per channel i, `level[i]`** (PWM_BITS wide), updated every edge with this priority:
  1. `pat[i]`==1 → MAX. Set wins over a simultaneous `fade_tick`.
  2. else if `fade_tick` → `level[i]` - FADE_STEP, saturating at 0. No wrap.
  3. else hold.
- **Per channel i, `shadow[i]`:**
  - Loads the current `level[i]` at the period boundary edge.
  - Holds otherwise.
  - Duty cycle therefore changes only at period starts, so no mid-period glitches.
- **Output:** `led_out[i]` <= (`shadow[i]`==MAX) || (`shadow[i]` > `cnt`).
  - MAX = 100% duty.
  - 0 = off.
  - Level L (0<L<MAX) = L/2^PWM_BITS duty.
- **Frame:** `frame` <= (`cnt`==MAX).
- **Reset** (asynchronous, immediate on `rs` high): `cnt`, `pre`, all `level`, all `shadow`, `led_out`=8'h00, `frame`=0.
  - Reset mid-fade discards all fade state.
  - The first edge after `rs` falls is counted as cycle 1 with `cnt` 0→1.

## Timing
- `pat[i]` rising at edge E: `level[i`]=MAX after E.
  - `shadow` picks it up at the next boundary edge B.
  - `led_out[i]` goes high at B+1 and stays high.
  - Worst-case latency 2^PWM_BITS+1 clocks.
- `pat[i]` falling: `level` holds MAX until the first `fade_tick` edge, then drops by FADE_STEP per tick.
  - Visible change follows at the next boundary +1.
- Within a period, `led_out[i]` for shadow level L is high for the L cycles following the boundary, offset by 1 for the output register.
- `frame` is high exactly 1 of every 2^PWM_BITS cycles.
  - First `frame` pulse occurs 2^PWM_BITS clocks after reset release.
- All state changes occur on rising `clk` except asynchronous reset assertion.

## Structure
- **Package `led_fade_pkg`:**
  - `NUM_LEDS`=8.
  - Default values of PWM_BITS, FADE_DIV, FADE_STEP.
  - Level type width derived from PWM_BITS.
- **Sub-module `led_fade_chan`:**
  - Contains one channel: the `level` register, the `shadow` register, and the comparator plus output flop.
  - Inputs: `clk`, `rs`, `pat_bit`, `fade_tick`, `boundary`, `cnt`.
  - Top level instantiates 8 copies (generate loop) and holds the shared `cnt`, `pre` and `frame` logic.

## Test plan
All scenarios use PWM_BITS=4, FADE_DIV=16, FADE_STEP=5, so the period is 16 clocks and `fade_tick` coincides with `cnt`==15.

1. **Reset:** assert `rs` for 3 cycles mid-run.
   - `led_out`=00 and `frame`=0 immediately, without waiting for a clock edge.
   - After release, first `frame` pulse 16 clocks later.
2. **Hold on:** hold `pat`=8'h01 from reset release.
   - `led_out[0]`=1 continuously from the cycle after the first boundary.
   - `led_out[7:1]`=0 throughout.
3. **Fade sequence:** `pat`=01 for 2 periods, then 00.
   - Successive shadow levels 15, 10, 5, 0.
   - `led_out[0]` high for 16, 10, 5, 0 cycles in the corresponding periods, then stays 0.
4. **Saturation:** force level 3 (`pat` pulse, then fade to 3 with FADE_STEP=4 variant).
   - Next tick yields 0, never 15.
5. **Set/tick collision:** `pat[3]` 0→1 on the edge where `fade_tick`=1 while level is 10.
   - Level becomes 15.
6. **Shifter stimulus:** drive FF, FE, FC, F8, F0, E0, C0, 80, 00, FF, advancing once per period.
   - Newly cleared bits fade from 15.
   - Bits still at 1 remain at 100% duty.
   - All channels return to 100% on FF.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared constants and helpers for the LED fade/PWM output stage.
package led_fade_pkg;

    localparam int unsigned NUM_LEDS      = 8;
    localparam int unsigned PWM_BITS_DEF  = 8;
    localparam int unsigned FADE_DIV_DEF  = 65536;
    localparam int unsigned FADE_STEP_DEF = 16;

    localparam int unsigned LEVEL_W = PWM_BITS_DEF;
    typedef logic [LEVEL_W-1:0] level_t;

    // Prescaler register width able to hold 0..div-1
    function automatic int unsigned pre_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: brightness level, period-aligned shadow copy and PWM output flop.
module led_fade_chan
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                rs,
    input  logic                pat_bit,
    input  logic                fade_tick,
    input  logic                boundary,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                led
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(FADE_STEP);

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] shadow_q, shadow_d;
    logic                led_q, led_d;

    // Pattern set beats a coincident fade tick; fading saturates at zero
    always_comb begin
        level_d = level_q;
        if (pat_bit) begin
            level_d = LVL_MAX;
        end else if (fade_tick) begin
            level_d = (level_q > STEP) ? level_q - STEP : '0;
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (boundary) begin
            shadow_d = level_q;
        end
        led_d = (shadow_q == LVL_MAX) || (shadow_q > cnt);
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            level_q  <= '0;
            shadow_q <= '0;
            led_q    <= 1'b0;
        end else begin
            level_q  <= level_d;
            shadow_q <= shadow_d;
            led_q    <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED fade stage: full brightness while the pattern bit is set, linear PWM fade-out after.
module led_fade_pwm
    import led_fade_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned FADE_DIV  = FADE_DIV_DEF,
    parameter int unsigned FADE_STEP = FADE_STEP_DEF
) (
    input  logic                clk,
    input  logic                rs,
    input  logic [NUM_LEDS-1:0] pat,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                frame
);

    localparam int unsigned         PRE_W    = pre_width(FADE_DIV);
    localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(FADE_DIV - 1);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic                frame_q, frame_d;
    logic                fade_tick_c;
    logic                boundary_c;

    assign fade_tick_c = (pre_q == PRE_LAST);
    assign boundary_c  = (cnt_q == CNT_MAX);

    // Shared PWM counter (wraps naturally) and fade prescaler
    always_comb begin
        cnt_d   = cnt_q + PWM_BITS'(1);
        pre_d   = fade_tick_c ? '0 : pre_q + PRE_W'(1);
        frame_d = boundary_c;
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            cnt_q   <= '0;
            pre_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            frame_q <= frame_d;
        end
    end

    assign frame = frame_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_fade_chan #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk       (clk),
            .rs        (rs),
            .pat_bit   (pat[g]),
            .fade_tick (fade_tick_c),
            .boundary  (boundary_c),
            .cnt       (cnt_q),
            .led       (led_out[g])
        );
    end

endmodule
